// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the game sequencer: state codes, direction bits, board ROM.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } game_state_t;

    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;

    localparam logic [2:0] BLANK = 3'b100;

    // Start boards; the blank always sits in the centre slot [5:3].
    localparam logic [11:0] BOARD_0 = {3'b000, 3'b001, BLANK, 3'b010};
    localparam logic [11:0] BOARD_1 = {3'b001, 3'b010, BLANK, 3'b000};
    localparam logic [11:0] BOARD_2 = {3'b010, 3'b000, BLANK, 3'b001};

    localparam logic [1:0] BOARD_LAST = 2'd2;

    // Board ROM lookup; the unused index 3 aliases to board 0.
    function automatic logic [11:0] board_rom(input logic [1:0] idx);
        case (idx)
            2'd1:    return BOARD_1;
            2'd2:    return BOARD_2;
            default: return BOARD_0;
        endcase
    endfunction

    // Keep only the lowest-index direction edge.
    function automatic logic [3:0] first_dir(input logic [3:0] edges);
        logic [3:0] one;
        one = '0;
        if (edges[DIR_UP])         one[DIR_UP]    = 1'b1;
        else if (edges[DIR_RIGHT]) one[DIR_RIGHT] = 1'b1;
        else if (edges[DIR_DOWN])  one[DIR_DOWN]  = 1'b1;
        else if (edges[DIR_LEFT])  one[DIR_LEFT]  = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button/status bundle between the board-level controls and the game sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all outputs are levels or single-cycle pulses.
interface game_sequencer_if;
    logic        btn_start;
    logic        btn_sel;
    logic [3:0]  btn_dir;
    logic        win_flag;
    logic [1:0]  game_status;
    logic [11:0] origin_board;
    logic [3:0]  act;
    logic        play_reset;
    logic [1:0]  board_idx;
    logic [7:0]  move_cnt;

    modport master (
        output btn_start, btn_sel, btn_dir, win_flag,
        input  game_status, origin_board, act, play_reset, board_idx, move_cnt
    );

    modport slave (
        input  btn_start, btn_sel, btn_dir, win_flag,
        output game_status, origin_board, act, play_reset, board_idx, move_cnt
    );
endinterface

// File: rtl/game_sequencer_btn_conditioner.sv
// Button conditioner: 2-flop synchroniser, optional stability debounce (GAME_SEQUENCER_DEBOUNCE_EN), rising-edge pulse.
// Latency: pulse 2 cycles after the raw rise (DB_CYCLES+2 with debounce).
// Backpressure: none; the pulse is one cycle wide and is not held.
module btn_conditioner #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [1:0] sync;
    logic       level;
    logic       level_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], raw};
    end

`ifdef GAME_SEQUENCER_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic [CNT_W-1:0] db_cnt;

    // Accept a new level only after DB_CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync[1] == level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
            level  <= sync[1];
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end
`else
    assign level = sync[1];

    // DB_CYCLES only shapes the debounce counter, which this build leaves out.
    if (DB_CYCLES < 1) begin : g_db_ignored
    end
`endif

    // Previous conditioned level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_d <= 1'b0;
        else        level_d <= level;
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: board selection, game start/restart, move pulses, win detection (debounce via GAME_SEQUENCER_DEBOUNCE_EN).
// Latency: act/state react 1 cycle after a conditioned button edge (3 cycles from raw press without debounce).
// Backpressure: none; presses arriving in a state that does not use them are dropped.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int WIN_HOLD  = 8
) (
    input  logic            clk_d,
    input  logic            reset,
    game_sequencer_if.slave bus
);

    localparam int          HOLD_W    = (WIN_HOLD < 1) ? 1 : $clog2(WIN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(WIN_HOLD);
    // Covers the reload cycle and the two cycles after it, while win_flag still reflects the old board.
    localparam logic [1:0]  GUARD_LEN = 2'd3;

    game_state_t       state;
    logic [1:0]        board_idx;
    logic [7:0]        move_cnt;
    logic [3:0]        act_q;
    logic              play_reset_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        guard;
    logic              win_q;

    logic              start_edge;
    logic              sel_edge;
    logic [3:0]        dir_edge;
    logic              win_ok;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clk   (clk_d),
        .rst_n (reset),
        .raw   (bus.btn_start),
        .pulse (start_edge)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_sel (
        .clk   (clk_d),
        .rst_n (reset),
        .raw   (bus.btn_sel),
        .pulse (sel_edge)
    );

    for (genvar i = 0; i < 4; i++) begin : g_dir
        btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_dir (
            .clk   (clk_d),
            .rst_n (reset),
            .raw   (bus.btn_dir[i]),
            .pulse (dir_edge[i])
        );
    end

    assign win_ok = bus.win_flag && (guard == 2'd0);

    // Game FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk_d or negedge reset) begin
        if (!reset) begin
            state        <= CHOSE_BOARD;
            board_idx    <= 2'd0;
            move_cnt     <= 8'd0;
            act_q        <= 4'd0;
            play_reset_q <= 1'b0;
            hold_cnt     <= '0;
            guard        <= 2'd0;
            win_q        <= 1'b0;
        end else begin
            act_q        <= 4'd0;
            play_reset_q <= 1'b0;
            if (guard != 2'd0) guard <= guard - 2'd1;

            case (state)
                CHOSE_BOARD: begin
                    hold_cnt <= '0;
                    if (sel_edge)
                        board_idx <= (board_idx >= BOARD_LAST) ? 2'd0 : board_idx + 2'd1;
                    if (start_edge)
                        state <= GAME_INITIAL;
                end

                GAME_INITIAL: begin
                    state        <= GAMING;
                    play_reset_q <= 1'b1;
                    move_cnt     <= 8'd0;
                    guard        <= GUARD_LEN;
                    win_q        <= 1'b0;
                end

                GAMING: begin
                    if (start_edge) begin
                        // Restart in place: reload the board, drop any move this cycle.
                        play_reset_q <= 1'b1;
                        move_cnt     <= 8'd0;
                        guard        <= GUARD_LEN;
                        win_q        <= 1'b0;
                    end else if (win_ok && win_q) begin
                        state    <= WINNED;
                        hold_cnt <= '0;
                        win_q    <= 1'b0;
                    end else begin
                        win_q <= win_ok;
                        if (dir_edge != 4'd0) begin
                            act_q <= first_dir(dir_edge);
                            if (move_cnt != 8'hFF) move_cnt <= move_cnt + 8'd1;
                        end
                    end
                end

                WINNED: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else if (start_edge) begin
                        state    <= CHOSE_BOARD;
                        hold_cnt <= '0;
                    end
                end

                default: state <= CHOSE_BOARD;
            endcase
        end
    end

    assign bus.game_status  = state;
    assign bus.origin_board = board_rom(board_idx);
    assign bus.act          = act_q;
    assign bus.play_reset   = play_reset_q;
    assign bus.board_idx    = board_idx;
    assign bus.move_cnt     = move_cnt;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (also exercises GAME_SEQUENCER_DEBOUNCE_EN when defined).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_game_sequencer;

`ifdef GAME_SEQUENCER_DEBOUNCE_EN
    localparam int DB  = 4;
    localparam int WH  = 16;
    localparam int LAT = DB + 3;
`else
    localparam int DB  = 4;
    localparam int WH  = 8;
    localparam int LAT = 3;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    game_sequencer_if bus ();

    game_sequencer #(.DB_CYCLES(DB), .WIN_HOLD(WH)) dut (
        .clk_d (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = start, 1 = sel; held until the reaction is visible.
    task automatic hold_btn(input int which);
        if (which == 0) bus.btn_start = 1'b1;
        else            bus.btn_sel   = 1'b1;
        repeat (LAT) tick();
    endtask

    task automatic release_btns();
        bus.btn_start = 1'b0;
        bus.btn_sel   = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    // Hold a direction pattern, then release; count act pulses over the whole window.
    task automatic dir_press(input logic [3:0] d, input int hold,
                             output int n, output logic [3:0] v, output int first);
        n = 0; v = 4'd0; first = 0;
        bus.btn_dir = d;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (bus.act != 4'd0) begin
                n++; v = bus.act;
                if (first == 0) first = i;
            end
        end
        bus.btn_dir = 4'd0;
        for (int i = 1; i <= LAT + 2; i++) begin
            tick();
            if (bus.act != 4'd0) begin
                n++; v = bus.act;
                if (first == 0) first = hold + i;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         n;
        int         first;
        logic [3:0] v;

        tests = 0; failed = 0;
        rst_n = 1'b0;
        bus.btn_start = 1'b0; bus.btn_sel = 1'b0; bus.btn_dir = 4'd0; bus.win_flag = 1'b0;
        repeat (3) tick();
        check("rst_status",  bus.game_status, 2'b00);
        check("rst_idx",     bus.board_idx, 2'd0);
        check("rst_moves",   bus.move_cnt, 8'd0);
        check("rst_act",     bus.act, 4'd0);
        check("rst_preset",  bus.play_reset, 1'b0);
        check("rst_origin",  bus.origin_board, 12'b000_001_100_010);
        rst_n = 1'b1;
        repeat (2) tick();

        // Board selection with wrap.
        hold_btn(1);
        check("sel1_idx",    bus.board_idx, 2'd1);
        check("sel1_origin", bus.origin_board, 12'b001_010_100_000);
        release_btns();
        hold_btn(1);
        check("sel2_idx",    bus.board_idx, 2'd2);
        check("sel2_origin", bus.origin_board, 12'b010_000_100_001);
        release_btns();
        hold_btn(1);
        check("sel3_wrap",   bus.board_idx, 2'd0);
        check("sel3_origin", bus.origin_board, 12'b000_001_100_010);
        release_btns();
        hold_btn(1);
        check("sel4_idx",    bus.board_idx, 2'd1);
        release_btns();

        // Direction ignored while choosing a board.
        dir_press(4'b0001, LAT + 3, n, v, first);
        check("chose_dir_n",   n, 0);
        check("chose_dir_cnt", bus.move_cnt, 8'd0);

        // Start: GAME_INITIAL for one cycle, then GAMING with play_reset.
        hold_btn(0);
        check("start_init",  bus.game_status, 2'b10);
        check("start_pr0",   bus.play_reset, 1'b0);
        tick();
        check("start_gaming", bus.game_status, 2'b01);
        check("start_pr1",   bus.play_reset, 1'b1);
        check("start_moves", bus.move_cnt, 8'd0);
        check("start_act",   bus.act, 4'd0);
        tick();
        check("start_pr_off", bus.play_reset, 1'b0);
        check("start_still", bus.game_status, 2'b01);
        release_btns();

        // Simultaneous right+down: only right, once.
        dir_press(4'b0110, LAT + 3, n, v, first);
        check("dual_n",     n, 1);
        check("dual_act",   v, 4'b0010);
        check("dual_when",  first, LAT);
        check("dual_moves", bus.move_cnt, 8'd1);
        dir_press(4'b1000, LAT + 3, n, v, first);
        check("left_act",   v, 4'b1000);
        check("left_moves", bus.move_cnt, 8'd2);

`ifdef GAME_SEQUENCER_DEBOUNCE_EN
        dir_press(4'b0001, 2, n, v, first);
        check("glitch_n",     n, 0);
        check("glitch_moves", bus.move_cnt, 8'd2);
`endif

        // Saturation of the move counter.
        for (int i = 0; i < 260; i++) begin
            bus.btn_dir = 4'b0001;
            repeat (LAT) tick();
            bus.btn_dir = 4'b0000;
            repeat (LAT + 1) tick();
        end
        check("sat_moves", bus.move_cnt, 8'd255);

        // Restart mid-game, with win_flag only inside the post-reload guard.
        hold_btn(0);
        check("restart_pr",     bus.play_reset, 1'b1);
        check("restart_moves",  bus.move_cnt, 8'd0);
        check("restart_status", bus.game_status, 2'b01);
        check("restart_act",    bus.act, 4'd0);
        tick();
        bus.win_flag = 1'b1;
        tick();
        tick();
        bus.win_flag = 1'b0;
        repeat (3) tick();
        check("guard_status", bus.game_status, 2'b01);
        release_btns();

        dir_press(4'b0100, LAT + 3, n, v, first);
        check("down_act",   v, 4'b0100);
        check("down_moves", bus.move_cnt, 8'd1);

        // Win after two consecutive samples.
        bus.win_flag = 1'b1;
        tick();
        check("win_one", bus.game_status, 2'b01);
        tick();
        bus.win_flag = 1'b0;
        check("win_two", bus.game_status, 2'b11);
        repeat (3) tick();
        hold_btn(0);
        check("win_early_start", bus.game_status, 2'b11);
        release_btns();
        dir_press(4'b0001, LAT + 3, n, v, first);
        check("win_dir_n",   n, 0);
        check("win_frozen",  bus.move_cnt, 8'd1);
        hold_btn(0);
        check("win_exit",     bus.game_status, 2'b00);
        check("win_keep_idx", bus.board_idx, 2'd1);
        release_btns();

        // Asynchronous reset mid-game with a direction held through deassertion.
        hold_btn(0);
        release_btns();
        bus.btn_dir = 4'b0010;
        repeat (LAT) tick();
        check("pre_rst_act",   bus.act, 4'b0010);
        check("pre_rst_moves", bus.move_cnt, 8'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_status", bus.game_status, 2'b00);
        check("async_act",    bus.act, 4'd0);
        check("async_moves",  bus.move_cnt, 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            if (bus.act != 4'd0) n++;
        end
        check("post_rst_act_n",  n, 0);
        check("post_rst_status", bus.game_status, 2'b00);
        bus.btn_dir = 4'd0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
